exponent_arbiter: RTL and testbench
===================================

# exponent_arbiter

Round-robin controller that shares one `exponent` core between `NUM_REQ` independent requesters, such as AXI slave front-ends or local FSMs. It accepts a job (X, A) from one requester at a time and sequences the core: a load pulse, then a start pulse, then a wait for done. It captures the result P and returns it on that requester's response channel. It sits between the bus-side register blocks and the single `exponent` instance.

## Interface
- `NUM_REQ`, default 2: number of requesters, from 2 to 8.
- `IDW`, default 1: grant-index width, equal to clog2(`NUM_REQ`), minimum 1.
- `TIMEOUT_CYCLES`, default 255: watchdog limit in RUN. Used only when `EXP_ARB_TIMEOUT_EN` is defined.

Ports:
- `i_clk`  in  1  single clock; all logic is on its rising edge.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_req_valid`  in  `NUM_REQ`  per-requester job valid.
- `o_req_ready`  out  `NUM_REQ`  per-requester job accept, one-hot or zero.
- `i_req_X`  in  4*`NUM_REQ`  packed X operands; requester k uses bits [4k+3:4k].
- `i_req_A`  in  4*`NUM_REQ`  packed A operands, same packing as `i_req_X`.
- `o_rsp_valid`  out  `NUM_REQ`  per-requester result valid, one-hot or zero.
- `i_rsp_ready`  in  `NUM_REQ`  per-requester result accept.
- `o_rsp_P`  out  15  result for the requester whose `o_rsp_valid` bit is set.
- `o_rsp_err`  out  1  timeout flag, qualified by `o_rsp_valid`.
- `o_core_load`, `o_core_start`  out  1  each  one-cycle pulses to the core.
- `o_core_X`, `o_core_A`  out  4  each  registered operands to the core.
- `i_core_done`  in  1  core done, a level signal.
- `i_core_P`  in  15  core result.
- `o_busy`  out  1  high in every state except IDLE.
- `o_grant_id`  out  `IDW`  index of the current or most recent grantee.

## Operation
- The FSM has five states: IDLE, LOAD, START, RUN, RESP.
- **IDLE**
  - If any `i_req_valid` bit is set, select winner w by round-robin, searching from `last_grant+1` with wrap-around modulo `NUM_REQ`.
  - Drive `o_req_ready[w]=1`; this is combinational and occurs in IDLE only.
  - Capture `i_req_X[w]` and `i_req_A[w]` into `o_core_X` and `o_core_A`.
  - Set `o_grant_id=w` and go to LOAD.
  - If no request is valid, stay in IDLE.
- **LOAD:** `o_core_load=1` for exactly one cycle, then go to START.
- **START:** `o_core_start=1` for exactly one cycle, then go to RUN.
- **RUN:** wait for `i_core_done=1`.
  - Done is sampled from the first RUN cycle onward. The core clears done on load, so a stale done from a previous job is never seen.
  - On done, register `o_rsp_P <= i_core_P`, `o_rsp_err <= 0`, and go to RESP.
- **RESP**
  - Hold `o_rsp_valid[w]=1`, with `o_rsp_P` and `o_rsp_err` stable, until `i_rsp_ready[w]=1`.
  - Then set `last_grant <= w` and go to IDLE.
- `i_rsp_ready` bits of non-granted requesters are ignored.
- Requests that arrive while busy keep `o_req_ready=0`. Requesters must hold `i_req_valid` and their operands stable until accepted.
- A requester that drops `i_req_valid` before it is granted is simply skipped.
- Operands are latched at acceptance. Later changes to `i_req_X` and `i_req_A` do not affect the running job.
- Only one job is in flight at a time; there is no queueing.

## Timing
- **Reset values:**
  - All outputs are 0.
  - State is IDLE.
  - `last_grant` is `NUM_REQ-1`, so requester 0 wins first.
  - `o_grant_id` is 0.
- **Reset mid-job:** asynchronous assertion aborts immediately to reset values. No response is issued, and the core is reset by the same `i_rst_n`.
- **Job latency:**
  - Acceptance at cycle 0.
  - Load at cycle 1.
  - Start at cycle 2.
  - RUN from cycle 3.
  - If done is first high at cycle 3+D, `o_rsp_valid` rises at cycle 4+D.
- **Back-to-back:** RESP handshake at cycle n returns to IDLE at n+1. The next acceptance can occur in cycle n+1.
- **Fairness:** with all requesters continuously valid, grants rotate 0,1,…,`NUM_REQ-1`,0. A requester waits at most `NUM_REQ-1` jobs.
- **Simultaneous events:**
  - A new request arriving in the same cycle as an `i_rsp_ready` handshake is not accepted until IDLE.
  - `i_core_done` seen in RESP, LOAD or START is ignored.
- `o_core_load` and `o_core_start` are never high together and never repeat within one job.

## Configuration
- **`EXP_ARB_TIMEOUT_EN` defined:**
  - A 16-bit counter clears on entry to RUN and increments each RUN cycle.
  - If it reaches `TIMEOUT_CYCLES` without done, go to RESP with `o_rsp_P=0` and `o_rsp_err=1`.
  - If done and the limit occur in the same cycle, done wins and `o_rsp_err=0`.
- **`EXP_ARB_TIMEOUT_EN` undefined:**
  - No counter is built and `o_rsp_err` is tied to 0.
  - RUN waits indefinitely.

## Test plan
The core is a behavioural model returning P = X^A mod 2^15, with done D=5 cycles after start.
- **Single job:** after reset, req0 sends X=2, A=3 -> `o_req_ready[0]` is high in cycle 0, load in cycle 1, start in cycle 2, `o_rsp_valid[0]` at cycle 9 with P=8 and err=0.
- **Contention and fairness:** req0 and req1 held valid for 4 jobs each with `i_rsp_ready` tied high -> grants are exactly 0,1,0,1,0,1,0,1. Back-to-back acceptance occurs one cycle after each response handshake.
- **Response backpressure:** req1 sends X=3, A=2 with `i_rsp_ready[1]` low for 10 cycles -> P=9 is held stable, `o_busy`=1, and a pending req0 stays un-accepted until the handshake.
- **Reset mid-RUN:** assert `i_rst_n`=0 at cycle 4 of a job -> all outputs are 0 immediately. After release, req1 is serviced before req0 only if req0 is not valid.
- **Timeout** (macro defined, `TIMEOUT_CYCLES`=20, core never asserts done) -> `o_rsp_valid` with err=1 and P=0 after 20 RUN cycles. With the macro undefined, `o_busy` stays 1 for 1000 cycles and `o_rsp_err` stays 0.

Source files
------------

// File: rtl/exponent_arbiter.sv
// Round-robin front end that time-shares a single exponent core between NUM_REQ requesters.
// Optional RUN watchdog is built only when EXP_ARB_TIMEOUT_EN is defined.
module exponent_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int IDW            = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [NUM_REQ-1:0]   i_req_valid,
  output logic [NUM_REQ-1:0]   o_req_ready,
  input  logic [4*NUM_REQ-1:0] i_req_X,
  input  logic [4*NUM_REQ-1:0] i_req_A,
  output logic [NUM_REQ-1:0]   o_rsp_valid,
  input  logic [NUM_REQ-1:0]   i_rsp_ready,
  output logic [14:0]          o_rsp_P,
  output logic                 o_rsp_err,
  output logic                 o_core_load,
  output logic                 o_core_start,
  output logic [3:0]           o_core_X,
  output logic [3:0]           o_core_A,
  input  logic                 i_core_done,
  input  logic [14:0]          i_core_P,
  output logic                 o_busy,
  output logic [IDW-1:0]       o_grant_id
);

  typedef enum logic [2:0] {IDLE, LOAD, START, RUN, RESP} state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] last_grant;
  logic [IDW-1:0] winner;
  logic           found;
  logic [3:0]     win_x, win_a;
  logic           rsp_hs;
  logic           timeout_hit;

  if (NUM_REQ < 2 || NUM_REQ > 8 || IDW != $clog2(NUM_REQ) || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("exponent_arbiter: illegal parameter combination");
  end

  // Search starts one past the previous grantee so every requester gets a turn.
  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    winner = '0;
    win_x = '0;
    win_a = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = int'(last_grant) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!found && k == idx && i_req_valid[k]) begin
          found  = 1'b1;
          winner = IDW'(k);
          win_x  = i_req_X[4*k +: 4];
          win_a  = i_req_A[4*k +: 4];
        end
      end
    end
  end

  always_comb begin
    o_req_ready = '0;
    o_rsp_valid = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      o_req_ready[k] = i_rst_n && (state == IDLE) && found && (winner == IDW'(k));
      o_rsp_valid[k] = (state == RESP) && (o_grant_id == IDW'(k));
    end
  end

  assign rsp_hs       = |(o_rsp_valid & i_rsp_ready);
  assign o_core_load  = (state == LOAD);
  assign o_core_start = (state == START);
  assign o_busy       = (state != IDLE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = LOAD;
      LOAD:    state_nxt = START;
      START:   state_nxt = RUN;
      RUN:     if (i_core_done || timeout_hit) state_nxt = RESP;
      RESP:    if (rsp_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_core_X   <= '0;
      o_core_A   <= '0;
      o_grant_id <= '0;
      last_grant <= IDW'(NUM_REQ - 1);
      o_rsp_P    <= '0;
    end else begin
      case (state)
        IDLE: if (found) begin
          o_core_X   <= win_x;
          o_core_A   <= win_a;
          o_grant_id <= winner;
        end
        RUN: begin
          if (i_core_done)      o_rsp_P <= i_core_P;
          else if (timeout_hit) o_rsp_P <= '0;
        end
        RESP: if (rsp_hs) last_grant <= o_grant_id;
        default: ;
      endcase
    end
  end

`ifdef EXP_ARB_TIMEOUT_EN
  logic [15:0] run_cnt;
  logic        rsp_err_q;

  // Counter is zeroed in START so it reads 0 on the first RUN cycle.
  assign timeout_hit = (run_cnt == 16'(TIMEOUT_CYCLES - 1));
  assign o_rsp_err   = rsp_err_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      run_cnt   <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      if (state == START)    run_cnt <= '0;
      else if (state == RUN) run_cnt <= run_cnt + 16'd1;
      if (state == RUN) begin
        if (i_core_done)      rsp_err_q <= 1'b0;
        else if (timeout_hit) rsp_err_q <= 1'b1;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign o_rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_exponent_arbiter.sv
// Directed bench for exponent_arbiter with a behavioural exponent core (P = X^A mod 2^15, D = 5).
module tb_exponent_arbiter;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b1;
  logic [1:0]  i_req_valid = '0;
  logic [1:0]  o_req_ready;
  logic [7:0]  i_req_X = '0;
  logic [7:0]  i_req_A = '0;
  logic [1:0]  o_rsp_valid;
  logic [1:0]  i_rsp_ready = '0;
  logic [14:0] o_rsp_P;
  logic        o_rsp_err;
  logic        o_core_load, o_core_start;
  logic [3:0]  o_core_X, o_core_A;
  logic        i_core_done;
  logic [14:0] i_core_P;
  logic        o_busy;
  logic [0:0]  o_grant_id;

  int checks = 0;
  int failures = 0;

  exponent_arbiter #(.NUM_REQ(2), .IDW(1), .TIMEOUT_CYCLES(20)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_X(i_req_X), .i_req_A(i_req_A),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_rsp_P(o_rsp_P), .o_rsp_err(o_rsp_err),
    .o_core_load(o_core_load), .o_core_start(o_core_start),
    .o_core_X(o_core_X), .o_core_A(o_core_A),
    .i_core_done(i_core_done), .i_core_P(i_core_P),
    .o_busy(o_busy), .o_grant_id(o_grant_id)
  );

  always #5 i_clk = ~i_clk;

  // Behavioural core: done is a level that rises 5 RUN cycles after start and clears on load.
  logic core_run;
  int   core_cnt;
  bit   core_hang = 1'b0;

  function automatic logic [14:0] powMod(input logic [3:0] x, input logic [3:0] a);
    int t;
    t = 1;
    for (int i = 0; i < int'(a); i++) t = (t * int'(x)) & 32'h7fff;
    return 15'(t);
  endfunction

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      core_run <= 1'b0;
      core_cnt <= 0;
      i_core_P <= '0;
    end else if (o_core_load) begin
      core_run <= 1'b0;
    end else if (o_core_start) begin
      core_run <= 1'b1;
      core_cnt <= 0;
      i_core_P <= powMod(o_core_X, o_core_A);
    end else if (core_run && core_cnt < 5) begin
      core_cnt <= core_cnt + 1;
    end
  end

  assign i_core_done = core_run && (core_cnt >= 5) && !core_hang;

  typedef struct {
    int req;
    int x;
    int a;
    int exp_p;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int k, input int x, input int a);
    i_req_valid[k]     = 1'b1;
    i_req_X[4*k +: 4]  = 4'(x);
    i_req_A[4*k +: 4]  = 4'(a);
  endtask

  task automatic doReset();
    i_rst_n     = 1'b0;
    i_req_valid = '0;
    i_rsp_ready = '0;
    core_hang   = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
  endtask

  function automatic int allOuts();
    return int'({o_req_ready, o_rsp_valid, o_rsp_P, o_rsp_err, o_core_load, o_core_start,
                 o_core_X, o_core_A, o_busy, o_grant_id});
  endfunction

  // One full job: acceptance in cycle 0, response expected in cycle 9.
  task automatic runVector(input vec_t v);
    int  cyc;
    bit  seen;
    tick();
    applyStimulus(v.req, v.x, v.a);
    settle();
    checkOutput("accept_ready", int'(o_req_ready), 1 << v.req);
    tick();
    i_req_valid = '0;
    i_req_X     = '1;
    i_req_A     = '1;
    settle();
    checkOutput("load_pulse", int'({o_core_load, o_core_start}), 2);
    checkOutput("core_X", int'(o_core_X), v.x);
    checkOutput("core_A", int'(o_core_A), v.a);
    checkOutput("grant_id", int'(o_grant_id), v.req);
    tick();
    settle();
    checkOutput("start_pulse", int'({o_core_load, o_core_start}), 1);
    cyc  = 2;
    seen = 1'b0;
    while (!seen && cyc < 40) begin
      tick();
      settle();
      cyc++;
      if (o_rsp_valid != 0) seen = 1'b1;
    end
    checkOutput("rsp_cycle", cyc, 9);
    checkOutput("rsp_valid", int'(o_rsp_valid), 1 << v.req);
    checkOutput("rsp_P", int'(o_rsp_P), v.exp_p);
    checkOutput("rsp_err", int'(o_rsp_err), 0);
    i_rsp_ready[v.req] = 1'b1;
    tick();
    i_rsp_ready = '0;
    settle();
    checkOutput("idle_after_hs", int'({o_busy, |o_rsp_valid}), 0);
  endtask

  initial begin
    int  grants[8];
    int  ng;
    int  cyc;
    bit  hs_prev, seen, blocked, stable, busy_ok, err_ok;

    vecs[0] = '{req: 0, x: 2,  a: 3,  exp_p: 8};
    vecs[1] = '{req: 1, x: 3,  a: 2,  exp_p: 9};
    vecs[2] = '{req: 0, x: 0,  a: 0,  exp_p: 1};
    vecs[3] = '{req: 1, x: 15, a: 15, exp_p: 2031};
    vecs[4] = '{req: 0, x: 2,  a: 15, exp_p: 0};
    vecs[5] = '{req: 1, x: 7,  a: 3,  exp_p: 343};

    #1 i_rst_n = 1'b0;
    i_req_valid = 2'b11;
    #2;
    checkOutput("reset_outputs", allOuts(), 0);
    doReset();

    $display("[TB] directed vectors");
    for (int i = 0; i < 6; i++) runVector(vecs[i]);

    $display("[TB] contention and fairness");
    doReset();
    i_req_X     = {4'd3, 4'd2};
    i_req_A     = {4'd1, 4'd1};
    i_req_valid = 2'b11;
    i_rsp_ready = 2'b11;
    ng = 0;
    hs_prev = 1'b0;
    cyc = 0;
    while (ng < 8 && cyc < 300) begin
      settle();
      if (o_req_ready != 0) begin
        grants[ng] = o_req_ready[1] ? 1 : 0;
        checkOutput("ready_onehot", $countones(o_req_ready), 1);
        if (ng > 0) checkOutput("b2b_accept", int'(hs_prev), 1);
        ng++;
      end
      hs_prev = |(o_rsp_valid & i_rsp_ready);
      tick();
      cyc++;
    end
    checkOutput("fair_jobs", ng, 8);
    for (int i = 0; i < 8; i++) checkOutput($sformatf("fair_grant_%0d", i), grants[i], i % 2);

    $display("[TB] response backpressure");
    doReset();
    applyStimulus(1, 3, 2);
    settle();
    checkOutput("bp_accept", int'(o_req_ready), 2);
    tick();
    i_req_valid = '0;
    applyStimulus(0, 2, 3);
    blocked = 1'b1;
    seen    = 1'b0;
    for (int c = 1; c < 40 && !seen; c++) begin
      settle();
      if (o_req_ready != 0) blocked = 1'b0;
      if (o_rsp_valid != 0) seen = 1'b1;
      else tick();
    end
    checkOutput("bp_rsp_seen", int'(seen), 1);
    i_rsp_ready = 2'b01;
    settle();
    stable = 1'b1;
    repeat (10) begin
      if (o_rsp_valid != 2'b10 || o_rsp_P != 15'd9 || !o_busy || o_req_ready != 0 || o_rsp_err)
        stable = 1'b0;
      tick();
      settle();
    end
    checkOutput("bp_hold_stable", int'(stable), 1);
    checkOutput("bp_req0_blocked", int'(blocked), 1);
    checkOutput("bp_P", int'(o_rsp_P), 9);
    i_rsp_ready = 2'b10;
    settle();
    checkOutput("hs_cycle_no_accept", int'(o_req_ready), 0);
    tick();
    i_rsp_ready = '0;
    settle();
    checkOutput("accept_after_hs", int'(o_req_ready), 1);

    $display("[TB] reset mid-RUN");
    doReset();
    applyStimulus(0, 2, 3);
    settle();
    checkOutput("mr_accept", int'(o_req_ready), 1);
    tick();
    i_req_valid = '0;
    tick();
    tick();
    tick();
    settle();
    checkOutput("mr_busy", int'(o_busy), 1);
    i_req_valid = 2'b11;
    i_rst_n = 1'b0;
    settle();
    checkOutput("mr_reset_outputs", allOuts(), 0);
    tick();
    tick();
    i_rst_n = 1'b1;
    settle();
    checkOutput("mr_req0_first", int'(o_req_ready), 1);
    i_rst_n = 1'b0;
    i_req_valid = 2'b10;
    tick();
    i_rst_n = 1'b1;
    settle();
    checkOutput("mr_req1_alone", int'(o_req_ready), 2);

    $display("[TB] hung core");
    doReset();
    runVector(vecs[0]);
    core_hang = 1'b1;
    tick();
    applyStimulus(0, 2, 3);
    settle();
    checkOutput("to_accept", int'(o_req_ready), 1);
    tick();
    i_req_valid = '0;
`ifdef EXP_ARB_TIMEOUT_EN
    cyc  = 1;
    seen = 1'b0;
    while (!seen && cyc < 100) begin
      settle();
      if (o_rsp_valid != 0) seen = 1'b1;
      else begin
        tick();
        cyc++;
      end
    end
    checkOutput("to_rsp_cycle", cyc, 23);
    checkOutput("to_err", int'(o_rsp_err), 1);
    checkOutput("to_P", int'(o_rsp_P), 0);
    i_rsp_ready = 2'b01;
    tick();
    i_rsp_ready = '0;
    settle();
    checkOutput("to_idle", int'(o_busy), 0);
`else
    busy_ok = 1'b1;
    err_ok  = 1'b1;
    repeat (1000) begin
      tick();
      settle();
      if (!o_busy) busy_ok = 1'b0;
      if (o_rsp_err) err_ok = 1'b0;
    end
    checkOutput("hang_busy", int'(busy_ok), 1);
    checkOutput("hang_err", int'(err_ok), 1);
`endif
    doReset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
